// File: rtl/vio_wb_mux.sv
// vio_wb_mux: registered Wishbone slave-side interconnect fanning one master out to NSLV peripheral channels.
// Optional build macro VIO_WB_TIMEOUT_EN adds a BUSY-state watchdog that ends silent transfers with an error.
module vio_wb_mux #(
  parameter int                   NSLV     = 4,
  parameter int                   DW       = 32,
  parameter int                   AW       = 32,
  parameter int                   DEC_HI   = 31,
  parameter int                   DEC_LO   = 12,
  parameter logic [NSLV*AW-1:0]   BASE_ADR = {NSLV{32'h0}},
  parameter int                   TIMEOUT  = 255
) (
  input  logic                 wbs_clk,
  input  logic                 wbs_rst_n,
  input  logic [AW-1:0]        wbs_adr_i,
  input  logic [DW-1:0]        wbs_dat_i,
  input  logic [DW/8-1:0]      wbs_sel_i,
  input  logic                 wbs_we_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_cyc_i,
  output logic [DW-1:0]        wbs_dat_o,
  output logic                 wbs_ack_o,
  output logic                 wbs_err_o,
  output logic                 wbs_stall_o,
  output logic [AW-1:0]        slv_adr_o,
  output logic [DW-1:0]        slv_dat_o,
  output logic [DW/8-1:0]      slv_sel_o,
  output logic                 slv_we_o,
  output logic [NSLV-1:0]      slv_cyc_o,
  output logic [NSLV-1:0]      slv_stb_o,
  input  logic [NSLV*DW-1:0]   slv_dat_i,
  input  logic [NSLV-1:0]      slv_ack_i,
  input  logic [NSLV-1:0]      slv_err_i
);

  localparam int IW  = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int DFW = DEC_HI - DEC_LO + 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP, ERR} state_t;

  state_t          state, state_nxt;
  logic            resp_ok, resp_ok_nxt;
  logic [IW-1:0]   idx, hit_idx;
  logic            hit, req;
  logic            sel_ack, sel_err;
  logic [DW-1:0]   sel_dat;
  logic            tmo_hit;

  assign req     = wbs_cyc_i & wbs_stb_i;
  assign sel_ack = slv_ack_i[idx];
  assign sel_err = slv_err_i[idx];
  assign sel_dat = slv_dat_i[idx*DW +: DW];

  // Descending scan so the lowest matching channel is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (wbs_adr_i[DEC_HI:DEC_LO] == BASE_ADR[i*AW+DEC_LO +: DFW]) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

`ifdef VIO_WB_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  always_ff @(posedge wbs_clk or negedge wbs_rst_n) begin
    if (!wbs_rst_n)
      tmo_cnt <= '0;
    else if (state != BUSY)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 16'd1;
  end

  assign tmo_hit = (tmo_cnt == 16'(TIMEOUT - 1));
`else
  // TIMEOUT is never 0, so without the watchdog BUSY never times out.
  assign tmo_hit = (TIMEOUT == 0);
`endif

  always_ff @(posedge wbs_clk or negedge wbs_rst_n) begin
    if (!wbs_rst_n) begin
      state   <= IDLE;
      resp_ok <= 1'b0;
    end else begin
      state   <= state_nxt;
      resp_ok <= resp_ok_nxt;
    end
  end

  // Master abort outranks any response seen in the same cycle; err outranks ack.
  always_comb begin
    state_nxt   = state;
    resp_ok_nxt = resp_ok;
    case (state)
      IDLE: begin
        if (req)
          state_nxt = hit ? BUSY : ERR;
      end
      BUSY: begin
        if (!wbs_cyc_i) begin
          state_nxt = IDLE;
        end else if (sel_err) begin
          state_nxt   = RESP;
          resp_ok_nxt = 1'b0;
        end else if (sel_ack) begin
          state_nxt   = RESP;
          resp_ok_nxt = 1'b1;
        end else if (tmo_hit) begin
          state_nxt   = RESP;
          resp_ok_nxt = 1'b0;
        end
      end
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wbs_clk or negedge wbs_rst_n) begin
    if (!wbs_rst_n) begin
      idx       <= '0;
      slv_adr_o <= '0;
      slv_dat_o <= '0;
      slv_sel_o <= '0;
      slv_we_o  <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      if (state == IDLE && req && hit) begin
        idx       <= hit_idx;
        slv_adr_o <= wbs_adr_i;
        slv_dat_o <= wbs_dat_i;
        slv_sel_o <= wbs_sel_i;
        slv_we_o  <= wbs_we_i;
      end
      if (state == BUSY && wbs_cyc_i && sel_ack && !sel_err && !slv_we_o)
        wbs_dat_o <= sel_dat;
    end
  end

  always_comb begin
    slv_stb_o = '0;
    if (state == BUSY)
      slv_stb_o[idx] = 1'b1;
  end

  assign slv_cyc_o   = slv_stb_o;
  assign wbs_ack_o   = (state == RESP) && resp_ok;
  assign wbs_err_o   = (state == ERR) || ((state == RESP) && !resp_ok);
  assign wbs_stall_o = (state != IDLE);

endmodule
